// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO with a fixed-latency busy countdown.
// Optional macro MD_DIV0_HOLD_EN: divide-by-zero leaves HI/LO unchanged on completion.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_e,
  input  logic        valid_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_d,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data_e,
  output logic        stall_d,
  output logic        proto_err
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               perr_q, perr_d;
`ifdef MD_DIV0_HOLD_EN
  logic               hold_q, hold_d;
`endif

  logic               op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic               is_muldiv, is_writer, rt_zero;
  logic [31:0]        divisor;
  logic [63:0]        smul, umul, result;
  logic signed [31:0] sq, sr;
  logic [31:0]        uq, ur;

  assign op_mult   = (md_op_e == 4'd1);
  assign op_multu  = (md_op_e == 4'd2);
  assign op_div    = (md_op_e == 4'd3);
  assign op_divu   = (md_op_e == 4'd4);
  assign op_mthi   = (md_op_e == 4'd5);
  assign op_mtlo   = (md_op_e == 4'd6);
  assign is_muldiv = op_mult | op_multu | op_div | op_divu;
  assign is_writer = is_muldiv | op_mthi | op_mtlo;
  assign rt_zero   = (rt_e == 32'd0);

  // Divider never sees zero; the zero case is substituted below.
  assign divisor = rt_zero ? 32'd1 : rt_e;

  assign smul = {{32{rs_e[31]}}, rs_e} * {{32{rt_e[31]}}, rt_e};
  assign umul = {32'd0, rs_e} * {32'd0, divisor == divisor ? rt_e : rt_e};
  assign sq   = $signed(rs_e) / $signed(divisor);
  assign sr   = $signed(rs_e) % $signed(divisor);
  assign uq   = rs_e / divisor;
  assign ur   = rs_e % divisor;

  always_comb begin
    result = 64'd0;
    if (op_mult)
      result = smul;
    else if (op_multu)
      result = umul;
    else if (rt_zero)
      result = {rs_e, 32'hFFFF_FFFF};
    else if (op_div)
      result = {sr, sq};
    else if (op_divu)
      result = {ur, uq};
  end

  assign start     = valid_e && is_muldiv && (state_q == IDLE);
  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign proto_err = perr_q;
  assign stall_d   = md_d && (start || busy_q);

  always_comb begin
    rd_data_e = 32'd0;
    if (md_op_e == 4'd7)
      rd_data_e = hi_q;
    else if (md_op_e == 4'd8)
      rd_data_e = lo_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    perr_d    = perr_q;
`ifdef MD_DIV0_HOLD_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          pend_hi_d = result[63:32];
          pend_lo_d = result[31:0];
          cnt_d     = (op_mult || op_multu) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          busy_d    = 1'b1;
          state_d   = BUSY;
`ifdef MD_DIV0_HOLD_EN
          hold_d    = (op_div || op_divu) && rt_zero;
`endif
        end else if (valid_e && op_mthi) begin
          hi_d = rs_e;
        end else if (valid_e && op_mtlo) begin
          lo_d = rs_e;
        end
      end
      BUSY: begin
        if (valid_e && is_writer)
          perr_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef MD_DIV0_HOLD_EN
          if (!hold_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
`else
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
`endif
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      perr_q    <= 1'b0;
`ifdef MD_DIV0_HOLD_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      perr_q    <= perr_d;
`ifdef MD_DIV0_HOLD_EN
      hold_q    <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: table-driven vectors plus hand sequences for divide, divide-by-zero and async reset.
// Divide-by-zero expectations follow MD_DIV0_HOLD_EN when it is defined.
module tb_md_sched;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op_e = 4'd0;
  logic        valid_e = 1'b0;
  logic [31:0] rs_e = 32'd0;
  logic [31:0] rt_e = 32'd0;
  logic        md_d = 1'b0;
  logic        start_w, busy_w, stall_w, perr_w;
  logic [31:0] hi_w, lo_w, rd_w;

  int vec_count = 0;
  int miss_count = 0;

  md_sched #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .md_op_e(md_op_e), .valid_e(valid_e),
    .rs_e(rs_e), .rt_e(rt_e), .md_d(md_d), .start(start_w), .busy(busy_w),
    .hi(hi_w), .lo(lo_w), .rd_data_e(rd_w), .stall_d(stall_w), .proto_err(perr_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        v;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md;
    logic        e_start;
    logic        e_busy;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [31:0] e_rd;
    logic        e_stall;
    logic        e_perr;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic [3:0] op, input logic v, input logic [31:0] rs,
                              input logic [31:0] rt, input logic md, input logic e_start,
                              input logic e_busy, input logic [31:0] e_hi, input logic [31:0] e_lo,
                              input logic [31:0] e_rd, input logic e_stall, input logic e_perr);
    vec_t r;
    r.op = op; r.v = v; r.rs = rs; r.rt = rt; r.md = md;
    r.e_start = e_start; r.e_busy = e_busy; r.e_hi = e_hi; r.e_lo = e_lo;
    r.e_rd = e_rd; r.e_stall = e_stall; r.e_perr = e_perr;
    return r;
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic [3:0] op, input logic v, input logic [31:0] rs,
                               input logic [31:0] rt, input logic md);
    @(negedge clk);
    md_op_e = op; valid_e = v; rs_e = rs; rt_e = rt; md_d = md;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic runDiv(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    applyStimulus(op, 1'b1, rs, rt, 1'b0);
    checkOutput({nm, ".start"}, {31'd0, start_w}, 32'd1);
    for (int i = 1; i <= DIV_CYCLES; i++) begin
      idle();
      checkOutput($sformatf("%s.busy%0d", nm, i), {31'd0, busy_w}, 32'd1);
      checkOutput($sformatf("%s.hold_hi%0d", nm, i), hi_w, prev_hi);
    end
    idle();
    checkOutput({nm, ".done"}, {31'd0, busy_w}, 32'd0);
    checkOutput({nm, ".hi"}, hi_w, exp_hi);
    checkOutput({nm, ".lo"}, lo_w, exp_lo);
  endtask

  initial begin
    logic [31:0] d0_hi, d0_lo;

    // op v rs rt md | start busy hi lo rd stall perr
    vecs[0]  = mk(4'd0, 0, 0, 0, 0,                        0, 0, 32'h0, 32'h0, 0, 0, 0);
    vecs[1]  = mk(4'd1, 1, 32'd3, 32'hFFFF_FFFE, 1,        1, 0, 32'h0, 32'h0, 0, 1, 0);
    vecs[2]  = mk(4'd0, 0, 0, 0, 1,                        0, 1, 32'h0, 32'h0, 0, 1, 0);
    vecs[3]  = mk(4'd0, 0, 0, 0, 1,                        0, 1, 32'h0, 32'h0, 0, 1, 0);
    vecs[4]  = mk(4'd0, 0, 0, 0, 1,                        0, 1, 32'h0, 32'h0, 0, 1, 0);
    vecs[5]  = mk(4'd0, 0, 0, 0, 1,                        0, 1, 32'h0, 32'h0, 0, 1, 0);
    vecs[6]  = mk(4'd0, 0, 0, 0, 1,                        0, 1, 32'h0, 32'h0, 0, 1, 0);
    vecs[7]  = mk(4'd0, 0, 0, 0, 1,                        0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 0);
    vecs[8]  = mk(4'd2, 1, 32'hFFFF_FFFF, 32'd2, 0,        1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 0);
    vecs[9]  = mk(4'd1, 1, 32'd9, 32'd9, 0,                0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 0);
    vecs[10] = mk(4'd0, 0, 0, 0, 0,                        0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 1);
    vecs[11] = mk(4'd0, 0, 0, 0, 0,                        0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 1);
    vecs[12] = mk(4'd0, 0, 0, 0, 0,                        0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 1);
    vecs[13] = mk(4'd0, 0, 0, 0, 0,                        0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 1);
    vecs[14] = mk(4'd7, 1, 0, 0, 0,                        0, 0, 32'd1, 32'hFFFF_FFFE, 32'd1, 0, 1);
    vecs[15] = mk(4'd5, 1, 32'h1234, 0, 0,                 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 1);
    vecs[16] = mk(4'd7, 1, 0, 0, 0,                        0, 0, 32'h1234, 32'hFFFF_FFFE, 32'h1234, 0, 1);
    vecs[17] = mk(4'd8, 1, 0, 0, 0,                        0, 0, 32'h1234, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 1);
    vecs[18] = mk(4'd6, 1, 32'h55, 0, 0,                   0, 0, 32'h1234, 32'hFFFF_FFFE, 0, 0, 1);
    vecs[19] = mk(4'd1, 0, 32'd4, 32'd4, 1,                0, 0, 32'h1234, 32'h55, 0, 0, 1);
    vecs[20] = mk(4'd0, 0, 0, 0, 1,                        0, 0, 32'h1234, 32'h55, 0, 0, 1);
    vecs[21] = mk(4'd12, 1, 32'd4, 32'd4, 1,               0, 0, 32'h1234, 32'h55, 0, 0, 1);
    vecs[22] = mk(4'd0, 0, 0, 0, 1,                        0, 0, 32'h1234, 32'h55, 0, 0, 1);

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].op, vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].md);
      checkOutput($sformatf("v%0d.start", i), {31'd0, start_w}, {31'd0, vecs[i].e_start});
      checkOutput($sformatf("v%0d.busy", i), {31'd0, busy_w}, {31'd0, vecs[i].e_busy});
      checkOutput($sformatf("v%0d.hi", i), hi_w, vecs[i].e_hi);
      checkOutput($sformatf("v%0d.lo", i), lo_w, vecs[i].e_lo);
      checkOutput($sformatf("v%0d.rd", i), rd_w, vecs[i].e_rd);
      checkOutput($sformatf("v%0d.stall", i), {31'd0, stall_w}, {31'd0, vecs[i].e_stall});
      checkOutput($sformatf("v%0d.perr", i), {31'd0, perr_w}, {31'd0, vecs[i].e_perr});
    end

    runDiv(4'd3, 32'hFFFF_FFF9, 32'd2, 32'h1234, 32'h55, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    runDiv(4'd4, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3, "divu");
`ifdef MD_DIV0_HOLD_EN
    d0_hi = 32'd1; d0_lo = 32'd3;
`else
    d0_hi = 32'd5; d0_lo = 32'hFFFF_FFFF;
`endif
    runDiv(4'd3, 32'd5, 32'd0, 32'd1, 32'd3, d0_hi, d0_lo, "div0");

    applyStimulus(4'd5, 1'b1, 32'h77, 32'd0, 1'b0);
    idle();
    checkOutput("mthi77", hi_w, 32'h77);

    // Asynchronous reset in the third busy cycle of a divide, away from any clock edge.
    applyStimulus(4'd3, 1'b1, 32'd100, 32'd3, 1'b0);
    applyStimulus(4'd1, 1'b1, 32'd2, 32'd2, 1'b0);
    idle();
    checkOutput("rst.perr_before", {31'd0, perr_w}, 32'd1);
    idle();
    checkOutput("rst.busy_before", {31'd0, busy_w}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst.busy", {31'd0, busy_w}, 32'd0);
    checkOutput("rst.hi", hi_w, 32'd0);
    checkOutput("rst.lo", lo_w, 32'd0);
    checkOutput("rst.perr", {31'd0, perr_w}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DIV_CYCLES + 2; i++) idle();
    checkOutput("rst.after_busy", {31'd0, busy_w}, 32'd0);
    checkOutput("rst.after_hi", hi_w, 32'd0);
    checkOutput("rst.after_lo", lo_w, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
